// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer. A CPU write to DMA_REG_ADDR halts the CPU through rdy,
// takes the memory bus and copies XFER_LEN bytes from page {P,8'h00} to
// OAM_DATA_ADDR as one read/write pair per byte. Otherwise the CPU bus passes
// straight through to memory.
module oam_dma_ctrl #(
   parameter int                    ADDR_WIDTH    = 16,
   parameter int                    REG_WIDTH     = 8,
   parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004,
   parameter int                    XFER_LEN      = 256
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic                  cpu_we,
   input  logic [REG_WIDTH-1:0]  cpu_wdata,
   output logic                  rdy,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [REG_WIDTH-1:0]  mem_din,
   input  logic [REG_WIDTH-1:0]  mem_dout,
   output logic                  busy
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   // Index of the final byte; the transfer stops here, so idx never wraps.
   localparam logic [REG_WIDTH-1:0] LAST_IDX = REG_WIDTH'(XFER_LEN - 1);

   state_t               state_q, state_d;
   logic [REG_WIDTH-1:0] page_q,  page_d;
   logic [REG_WIDTH-1:0] idx_q,   idx_d;
   logic [REG_WIDTH-1:0] data_q,  data_d;
   logic                 odd_q;

   // Source addresses are page-relative: the page byte never changes and the
   // index fills the low byte, so the copy cannot cross into the next page.
   logic [2*REG_WIDTH-1:0] src_addr;
   logic [2*REG_WIDTH-1:0] align_addr;

   assign src_addr   = {page_q, idx_q};
   assign align_addr = {page_q, {REG_WIDTH{1'b0}}};

   // State and datapath registers; odd_q is a free-running cycle parity.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         page_q  <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         odd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         odd_q   <= ~odd_q;
      end
   end

   // Next-state logic and bus ownership: pass-through unless in ALIGN/READ/WRITE.
   always_comb begin
      state_d  = state_q;
      page_d   = page_q;
      idx_d    = idx_q;
      data_d   = data_q;
      rdy      = 1'b1;
      busy     = 1'b0;
      mem_addr = cpu_addr;
      mem_we   = cpu_we;
      mem_din  = cpu_wdata;

      case (state_q)
         ST_IDLE: begin
            // The trigger write itself still reaches memory via pass-through.
            if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
               page_d  = cpu_wdata;
               idx_d   = '0;
               state_d = ST_HALT;
            end
         end

         ST_HALT: begin
            // CPU keeps the bus this cycle so its in-flight access completes;
            // a write to the DMA register here does not re-latch the page.
            rdy     = 1'b0;
            busy    = 1'b1;
            state_d = odd_q ? ST_ALIGN : ST_READ;
         end

         ST_ALIGN: begin
            rdy      = 1'b0;
            busy     = 1'b1;
            mem_we   = 1'b0;
            mem_addr = ADDR_WIDTH'(align_addr);
            mem_din  = data_q;
            state_d  = ST_READ;
         end

         ST_READ: begin
            rdy      = 1'b0;
            busy     = 1'b1;
            mem_we   = 1'b0;
            mem_addr = ADDR_WIDTH'(src_addr);
            mem_din  = data_q;
            data_d   = mem_dout;
            state_d  = ST_WRITE;
         end

         ST_WRITE: begin
            rdy      = 1'b0;
            busy     = 1'b1;
            mem_we   = 1'b1;
            mem_addr = OAM_DATA_ADDR;
            mem_din  = data_q;
            if (idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_READ;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
